// File: rtl/imem_program_loader_if.sv
// Stream-in / instruction-memory-write bundle for the boot image loader.
// The loader connects through the slave modport; the byte source and the
// memory model sit on the master side.
interface imem_program_loader_if #(
    parameter int size      = 32,
    parameter int AddrWidth = 9
);
    logic [7:0]           byte_in;
    logic                 byte_valid;
    logic                 byte_ready;
    logic                 imem_wea;
    logic [AddrWidth-1:0] imem_addra;
    logic [size-1:0]      imem_dina;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  imem_wea,
        input  imem_addra,
        input  imem_dina
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output imem_wea,
        output imem_addra,
        output imem_dina
    );
endinterface

// File: rtl/imem_program_loader.sv
// Boot-time instruction memory loader.
// Frame: N (16-bit, big-endian) | 4N payload bytes (words big-endian) | checksum.
// The checksum is the XOR of every header and payload byte. The core is held
// in reset until a whole image has been written and its checksum matches.
module imem_program_loader #(
    parameter int size      = 32,
    parameter int MemSize   = 512,
    parameter int AddrWidth = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    imem_program_loader_if.slave  bus,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HDR_HI = 3'd1;
    localparam logic [2:0] HDR_LO = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;  // one-cycle memory write slot
    localparam logic [2:0] CHECK  = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
    localparam logic [2:0] ERROR  = 3'd7;

    localparam logic [15:0] MEM_SIZE_W = MemSize[15:0];

    logic [2:0]           state_q,  state_d;
    logic                 ready_q,  ready_d;
    logic                 wea_q,    wea_d;
    logic [AddrWidth-1:0] addra_q,  addra_d;
    logic [size-1:0]      dina_q,   dina_d;
    logic                 hold_q,   hold_d;
    logic                 done_q,   done_d;
    logic                 error_q,  error_d;
    logic [15:0]          count_q,  count_d;
    logic [15:0]          n_q,      n_d;
    logic [7:0]           csum_q,   csum_d;
    logic [size-9:0]      asm_q,    asm_d;   // first three bytes of a word
    logic [1:0]           idx_q,    idx_d;   // byte position within a word

    logic                 accept_s;
    logic [15:0]          n_full_s;
    logic [15:0]          count_inc_s;

    // Byte handshake and helper values shared by the next-state logic.
    always_comb begin
        accept_s    = ready_q & bus.byte_valid;
        n_full_s    = {n_q[15:8], bus.byte_in};
        count_inc_s = count_q + 16'd1;
    end

    // Next-state and next-output computation for the load sequencer.
    always_comb begin
        state_d = state_q;
        wea_d   = 1'b0;
        addra_d = addra_q;
        dina_d  = dina_q;
        hold_d  = hold_q;
        done_d  = done_q;
        error_d = error_q;
        count_d = count_q;
        n_d     = n_q;
        csum_d  = csum_q;
        asm_d   = asm_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = HDR_HI;
                    csum_d  = 8'd0;
                    count_d = 16'd0;
                    addra_d = {AddrWidth{1'b0}};
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    idx_d   = 2'd0;
                end else begin
                    state_d = state_q;
                end
            end
            HDR_HI: begin
                if (accept_s) begin
                    n_d[15:8] = bus.byte_in;
                    csum_d    = csum_q ^ bus.byte_in;
                    state_d   = HDR_LO;
                end else begin
                    state_d = state_q;
                end
            end
            HDR_LO: begin
                if (accept_s) begin
                    n_d    = n_full_s;
                    csum_d = csum_q ^ bus.byte_in;
                    idx_d  = 2'd0;
                    if (n_full_s > MEM_SIZE_W) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                        hold_d  = 1'b1;
                    end else if (n_full_s == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DATA: begin
                if (accept_s) begin
                    csum_d = csum_q ^ bus.byte_in;
                    if (idx_q == 2'd3) begin
                        wea_d   = 1'b1;
                        dina_d  = {asm_q, bus.byte_in};
                        idx_d   = 2'd0;
                        state_d = WRITE;
                    end else begin
                        asm_d = {asm_q[size-17:0], bus.byte_in};
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            WRITE: begin
                // The write happened this cycle; advance the word pointer.
                count_d = count_inc_s;
                addra_d = count_inc_s[AddrWidth-1:0];
                if (count_inc_s == n_q) begin
                    state_d = CHECK;
                end else begin
                    state_d = DATA;
                end
            end
            CHECK: begin
                if (accept_s) begin
                    if (bus.byte_in == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                        hold_d  = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = 1'b1;
            end
        endcase
    end

    // byte_ready is registered, so it is derived from the state being entered.
    always_comb begin
        case (state_d)
            HDR_HI, HDR_LO, DATA, CHECK: ready_d = 1'b1;
            default:                     ready_d = 1'b0;
        endcase
    end

    // State and output registers; reset keeps the core held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            wea_q   <= 1'b0;
            addra_q <= {AddrWidth{1'b0}};
            dina_q  <= {size{1'b0}};
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            count_q <= 16'd0;
            n_q     <= 16'd0;
            csum_q  <= 8'd0;
            asm_q   <= {(size-8){1'b0}};
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            error_q <= error_d;
            count_q <= count_d;
            n_q     <= n_d;
            csum_q  <= csum_d;
            asm_q   <= asm_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.imem_wea   = wea_q;
    assign bus.imem_addra = addra_q;
    assign bus.imem_dina  = dina_q;
    assign cpu_hold       = hold_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_loaded   = count_q;

endmodule
